// File: rtl/kernel_seq_ctrl_pkg.sv
// Shared types and defaults for the convolution job sequencer.
package kernel_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned PIPE_LAT_DEF = 3;

  // Per-chunk flags that travel alongside the data to the accumulator.
  typedef struct packed {
    logic en;
    logic clr;
    logic last;
  } acc_flags_t;

  localparam int unsigned FLAG_W = $bits(acc_flags_t);

endpackage

// File: rtl/kernel_seq_ctrl_delay_line.sv
// Reset-clearable shift register; output is the input delayed by DEPTH clocks.
module seq_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/kernel_seq_ctrl.sv
// Sequences one convolution job: buffer address generation, accumulator strobes
// aligned to the datapath latency, per-pixel valid and job done.
module kernel_seq_ctrl
  import kernel_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_nch,
  input  logic [CNT_W-1:0]  i_npix,
  input  logic [ADDR_W-1:0] i_if_base,
  input  logic [ADDR_W-1:0] i_w_base,
  input  logic              i_stall,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_if_addr,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic              o_acc_en,
  output logic              o_acc_clr,
  output logic              o_acc_last,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [CNT_W-1:0] DrainLast = CNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0] One       = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  nch_q, npix_q, ch_q, pix_q, drain_q;
  logic [ADDR_W-1:0] w_base_q, if_addr_q, w_addr_q;
  logic              busy_q, done_q, out_valid_q;
  logic              issue, ch_last, pix_last;
  acc_flags_t        issue_flags, acc_flags;

  assign issue    = (state == S_RUN) && !i_stall;
  assign ch_last  = (ch_q == nch_q - One);
  assign pix_last = (pix_q == npix_q - One);

  // Flags of a stalled cycle are zero so bubbles carry no clr/last.
  always_comb begin
    issue_flags      = '0;
    issue_flags.en   = issue;
    issue_flags.clr  = issue && (ch_q == '0);
    issue_flags.last = issue && ch_last;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      nch_q     <= '0;
      npix_q    <= '0;
      ch_q      <= '0;
      pix_q     <= '0;
      drain_q   <= '0;
      w_base_q  <= '0;
      if_addr_q <= '0;
      w_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            nch_q     <= i_nch;
            npix_q    <= i_npix;
            ch_q      <= '0;
            pix_q     <= '0;
            drain_q   <= '0;
            w_base_q  <= i_w_base;
            if_addr_q <= i_if_base;
            w_addr_q  <= i_w_base;
            busy_q    <= 1'b1;
            if (i_nch == '0 || i_npix == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!i_stall) begin
            if_addr_q <= if_addr_q + ADDR_W'(1);
            if (ch_last) begin
              ch_q     <= '0;
              pix_q    <= pix_q + One;
              w_addr_q <= w_base_q;
              if (pix_last) begin
                state   <= S_DRAIN;
                drain_q <= '0;
              end
            end else begin
              ch_q     <= ch_q + One;
              w_addr_q <= w_addr_q + ADDR_W'(1);
            end
          end
        end
        // Wait until the final out_valid has been presented.
        S_DRAIN: begin
          if (drain_q == DrainLast) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            drain_q <= drain_q + One;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  seq_delay_line #(
    .WIDTH (FLAG_W),
    .DEPTH (PIPE_LAT)
  ) u_flag_pipe (
    .clk  (CLK),
    .rst  (RST),
    .din  (issue_flags),
    .dout (acc_flags)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) out_valid_q <= 1'b0;
    else     out_valid_q <= acc_flags.last;
  end

  assign o_rd_en     = issue;
  assign o_if_addr   = if_addr_q;
  assign o_w_addr    = w_addr_q;
  assign o_acc_en    = acc_flags.en;
  assign o_acc_clr   = acc_flags.clr;
  assign o_acc_last  = acc_flags.last;
  assign o_out_valid = out_valid_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_kernel_seq_ctrl.sv
// Directed bench for kernel_seq_ctrl: per-cycle expected strobes given as bit masks.
module tb_kernel_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_start;
  logic [7:0]  i_nch, i_npix;
  logic [11:0] i_if_base, i_w_base;
  logic        i_stall;
  logic        o_rd_en, o_acc_en, o_acc_clr, o_acc_last, o_out_valid, o_busy, o_done;
  logic [11:0] o_if_addr, o_w_addr;

  int n_assert = 0;
  int n_fail   = 0;

  kernel_seq_ctrl #(
    .ADDR_W   (12),
    .CNT_W    (8),
    .PIPE_LAT (3)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_start     (i_start),
    .i_nch       (i_nch),
    .i_npix      (i_npix),
    .i_if_base   (i_if_base),
    .i_w_base    (i_w_base),
    .i_stall     (i_stall),
    .o_rd_en     (o_rd_en),
    .o_if_addr   (o_if_addr),
    .o_w_addr    (o_w_addr),
    .o_acc_en    (o_acc_en),
    .o_acc_clr   (o_acc_clr),
    .o_acc_last  (o_acc_last),
    .o_out_valid (o_out_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] all_outs();
    return {o_rd_en, o_if_addr, o_w_addr, o_acc_en, o_acc_clr, o_acc_last,
            o_out_valid, o_busy, o_done};
  endfunction

  // Cycle c is the cycle after edge c-1, where edge 0 samples i_start.
  // Flags vector order: {rd_en, acc_en, clr, last, out_valid, busy, done}.
  task automatic run_job(input string tag, input logic [7:0] nch, input logic [7:0] npix,
                         input logic [11:0] ifb, input logic [11:0] wb,
                         input logic [63:0] stall_m, input logic [63:0] start_m,
                         input logic [63:0] rd_m, input logic [63:0] acc_m,
                         input logic [63:0] clr_m, input logic [63:0] last_m,
                         input logic [63:0] ov_m, input int done_cyc, input int ncyc);
    int         issued;
    logic [6:0] exp_f;
    logic [11:0] exp_if, exp_w;
    @(posedge CLK);
    #1;
    i_nch = nch; i_npix = npix; i_if_base = ifb; i_w_base = wb;
    i_start = 1'b1; i_stall = 1'b0;
    issued = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge CLK);
      #1;
      i_start = start_m[cyc];
      i_stall = stall_m[cyc];
      if (cyc == 1) begin
        i_nch = 8'd7; i_npix = 8'd9; i_if_base = 12'hABC; i_w_base = 12'h123;
      end
      @(negedge CLK);
      exp_f = {rd_m[cyc], acc_m[cyc], clr_m[cyc], last_m[cyc], ov_m[cyc],
               cyc <= done_cyc, cyc == done_cyc};
      chk($sformatf("%s_flags_c%0d", tag, cyc),
          64'({o_rd_en, o_acc_en, o_acc_clr, o_acc_last, o_out_valid, o_busy, o_done}),
          64'(exp_f));
      if (rd_m[cyc] || stall_m[cyc]) begin
        exp_if = ifb + 12'(issued);
        exp_w  = wb + 12'(issued % int'(nch));
        chk($sformatf("%s_addr_c%0d", tag, cyc), 64'({o_if_addr, o_w_addr}),
            64'({exp_if, exp_w}));
      end
      if (rd_m[cyc]) issued++;
    end
    i_start = 1'b0;
    i_stall = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    i_start = 1'b0; i_stall = 1'b0;
    i_nch = '0; i_npix = '0; i_if_base = '0; i_w_base = '0;
    #1;
    chk("reset_outs", 64'(all_outs()), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_outs", 64'(all_outs()), 64'd0);

    // nch=4, npix=2: 8 issues, pixels close at chunk 3 and 7.
    run_job("basic", 8'd4, 8'd2, 12'h100, 12'h200, 64'h0, 64'h0,
            64'h1FE, 64'hFF0, 64'h110, 64'h880, 64'h1100, 13, 14);

    // nch=1: clr and last coincide; three back-to-back out_valid.
    run_job("nch1", 8'd1, 8'd3, 12'h010, 12'h020, 64'h0, 64'h0,
            64'hE, 64'h70, 64'h70, 64'h70, 64'hE0, 8, 9);

    // Stall cycles 2..3 open a two-cycle gap and push done out by 2.
    run_job("stall", 8'd3, 8'd1, 12'h050, 12'h060, 64'hC, 64'h0,
            64'h32, 64'h190, 64'h10, 64'h100, 64'h200, 10, 11);

    // Empty jobs go straight to DONE.
    run_job("nch0", 8'd0, 8'd5, 12'h300, 12'h400, 64'h0, 64'h0,
            64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1, 3);
    run_job("npix0", 8'd3, 8'd0, 12'h300, 12'h400, 64'h0, 64'h0,
            64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1, 3);

    // Start pulses in RUN, DRAIN and DONE must be ignored.
    run_job("restart", 8'd4, 8'd2, 12'h100, 12'h200, 64'h0, 64'h2408,
            64'h1FE, 64'hFF0, 64'h110, 64'h880, 64'h1100, 13, 15);

    // Reset in the middle of a long job.
    @(posedge CLK);
    #1;
    i_nch = 8'd8; i_npix = 8'd4; i_if_base = 12'h040; i_w_base = 12'h080; i_start = 1'b1;
    @(posedge CLK);
    #1;
    i_start = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("midrun_busy", 64'(o_busy), 64'd1);
    RST = 1'b1;
    #1;
    chk("midrun_reset_outs", 64'(all_outs()), 64'd0);
    @(negedge CLK);
    chk("reset_hold_outs", 64'(all_outs()), 64'd0);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("post_reset_idle_%0d", i), 64'(all_outs()), 64'd0);
    end

    // Full 8x4 job after reset; ifmap base near the top checks wrap-around.
    run_job("full", 8'd8, 8'd4, 12'hFF0, 12'h080, 64'h0, 64'h0,
            64'h1_FFFF_FFFE, 64'hF_FFFF_FFF0, 64'h1010_1010, 64'h8_0808_0800,
            64'h10_1010_1000, 37, 38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
